// File: rtl/btn_event_pkg.sv
// Shared event codes, event record and per-button FSM state type for the
// front-panel button conditioner.
package btn_event_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef struct packed {
        logic [2:0] btn;
        logic [1:0] code;
    } btn_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } btn_st_e;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stable-count debounce and the
// PRESS/RELEASE/LONG/REPEAT classifier with a registered event output.
module btn_debounce
    import btn_event_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_raw,
    output logic       o_state,
    output logic       o_evt_vld,
    output logic [1:0] o_evt_code
);

    localparam int   DB_W     = $clog2(DEBOUNCE_CYC);
    localparam int   HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int   HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_state;
    logic [DB_W-1:0]   r_db_cnt;
    logic              w_pressed;

    btn_st_e           r_st;
    btn_st_e           w_st_nxt;
    logic [HOLD_W-1:0] r_cnt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic              r_evt_vld;
    logic              w_evt_vld;
    logic [1:0]        r_evt_code;
    logic [1:0]        w_evt_code;

    assign w_pressed = r_sync2 ^ IDLE_LVL;

    // The synchroniser idles at the released pad level so a button held
    // through reset is seen as a fresh press once reset lifts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1  <= IDLE_LVL;
            r_sync2  <= IDLE_LVL;
            r_state  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (w_pressed == r_state) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
                r_state  <= w_pressed;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Release is tested before the terminal counts so it wins a tie.
    always_comb begin
        w_st_nxt   = r_st;
        w_cnt_nxt  = r_cnt + HOLD_W'(1);
        w_evt_vld  = 1'b0;
        w_evt_code = EVT_PRESS;
        case (r_st)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (r_state) begin
                    w_st_nxt   = ST_DOWN;
                    w_evt_vld  = 1'b1;
                    w_evt_code = EVT_PRESS;
                end
            end
            ST_DOWN: begin
                if (!r_state) begin
                    w_st_nxt   = ST_IDLE;
                    w_evt_vld  = 1'b1;
                    w_evt_code = EVT_RELEASE;
                end else if (r_cnt == HOLD_W'(LONG_CYC - 1)) begin
                    w_st_nxt   = ST_HELD;
                    w_cnt_nxt  = '0;
                    w_evt_vld  = 1'b1;
                    w_evt_code = EVT_LONG;
                end
            end
            ST_HELD: begin
                if (!r_state) begin
                    w_st_nxt   = ST_IDLE;
                    w_evt_vld  = 1'b1;
                    w_evt_code = EVT_RELEASE;
                end else if (r_cnt == HOLD_W'(REPEAT_CYC - 1)) begin
                    w_cnt_nxt  = '0;
                    w_evt_vld  = 1'b1;
                    w_evt_code = EVT_REPEAT;
                end
            end
            default: begin
                w_st_nxt  = ST_IDLE;
                w_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st       <= ST_IDLE;
            r_cnt      <= '0;
            r_evt_vld  <= 1'b0;
            r_evt_code <= EVT_PRESS;
        end else begin
            r_st       <= w_st_nxt;
            r_cnt      <= w_cnt_nxt;
            r_evt_vld  <= w_evt_vld;
            r_evt_code <= w_evt_code;
        end
    end

    assign o_state    = r_state;
    assign o_evt_vld  = r_evt_vld;
    assign o_evt_code = r_evt_code;

endmodule

// File: rtl/btn_event_ctrl.sv
// Button conditioner top: per-button debounce/classify, one pending slot per
// button, fixed-priority arbiter and a registered-head event FIFO.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYC   = 1000000,
    parameter int LONG_CYC       = 50000000,
    parameter int REPEAT_CYC     = 10000000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic               i_aclk,
    input  logic               i_aresetn,
    input  logic [NUM_BTN-1:0] i_btn_raw,
    output logic [NUM_BTN-1:0] o_btn_state,
    output logic               o_evt_valid,
    input  logic               i_evt_ready,
    output logic [2:0]         o_evt_btn,
    output logic [1:0]         o_evt_code,
    output logic               o_irq,
    output logic               o_ovf,
    input  logic               i_ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_BTN-1:0] w_evt_vld;
    logic [1:0]         w_evt_code [NUM_BTN];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .ACTIVE_LOW   (BTN_ACTIVE_LOW),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_debounce (
            .i_clk      (i_aclk),
            .i_rst_n    (i_aresetn),
            .i_raw      (i_btn_raw[g]),
            .o_state    (o_btn_state[g]),
            .o_evt_vld  (w_evt_vld[g]),
            .o_evt_code (w_evt_code[g])
        );
    end

    logic [NUM_BTN-1:0] r_pend_vld;
    logic [1:0]         r_pend_code [NUM_BTN];
    logic [NUM_BTN-1:0] w_sel;
    logic [NUM_BTN-1:0] w_take;
    btn_evt_t           w_push_evt;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_drop;
    logic               r_ovf;

    btn_evt_t           r_mem [FIFO_DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [AW:0]        w_wr_nxt;
    logic [AW:0]        w_rd_nxt;
    logic               r_head_vld;
    btn_evt_t           r_head;

    // Scanning downward leaves the lowest occupied index selected.
    always_comb begin
        w_sel      = '0;
        w_push_evt = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_pend_vld[i]) begin
                w_sel           = '0;
                w_sel[i]        = 1'b1;
                w_push_evt.btn  = 3'(i);
                w_push_evt.code = r_pend_code[i];
            end
        end
    end

    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = r_head_vld & i_evt_ready;
    assign w_push   = (|r_pend_vld) & (~w_full | w_pop);
    assign w_take   = w_sel & {NUM_BTN{w_push}};
    assign w_drop   = |(w_evt_vld & r_pend_vld & ~w_take);
    assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // A slot freed by this cycle's push may accept that button's next event.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_pend_vld <= '0;
            for (int i = 0; i < NUM_BTN; i++) r_pend_code[i] <= EVT_PRESS;
            r_ovf <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_evt_vld[i] && (!r_pend_vld[i] || w_take[i])) begin
                    r_pend_vld[i]  <= 1'b1;
                    r_pend_code[i] <= w_evt_code[i];
                end else if (w_take[i]) begin
                    r_pend_vld[i] <= 1'b0;
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_aclk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_push_evt;
    end

    // The head register is refilled from the post-update read pointer; when
    // that slot is being written this cycle the push data is forwarded.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_head_vld <= 1'b0;
            r_head     <= '0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_head_vld <= (w_rd_nxt != w_wr_nxt);
            if (w_push && (w_rd_nxt == r_wr_ptr)) begin
                r_head <= w_push_evt;
            end else if (w_rd_nxt != r_wr_ptr) begin
                r_head <= r_mem[w_rd_nxt[AW-1:0]];
            end
        end
    end

    assign o_evt_valid = r_head_vld;
    assign o_evt_btn   = r_head.btn;
    assign o_evt_code  = r_head.code;
    assign o_irq       = r_head_vld;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Randomised and directed bench for btn_event_ctrl with a queue-based
// scoreboard fed by a timestamp-level reference model.
module tb_btn_event_ctrl;
    import btn_event_pkg::*;

    localparam int NB    = 4;
    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int REP   = 8;
    localparam int DEPTH = 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [NB-1:0] pr   = '0;
    logic [NB-1:0] raw;
    logic          ready   = 1'b1;
    logic          ovf_clr = 1'b0;
    logic [NB-1:0] btn_state;
    logic          evt_valid, irq, ovf;
    logic [2:0]    evt_btn;
    logic [1:0]    evt_code;

    assign raw = ~pr;
    always #5 clk = ~clk;

    btn_event_ctrl #(
        .NUM_BTN(NB), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYC(DEB),
        .LONG_CYC(LONG), .REPEAT_CYC(REP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_aclk(clk), .i_aresetn(rstn), .i_btn_raw(raw), .o_btn_state(btn_state),
        .o_evt_valid(evt_valid), .i_evt_ready(ready), .o_evt_btn(evt_btn),
        .o_evt_code(evt_code), .o_irq(irq), .o_ovf(ovf), .i_ovf_clr(ovf_clr)
    );

    int ncmp = 0;
    int nbad = 0;
    int n_hs = 0;

    logic [NB-1:0] m_s1, m_s2, m_ds, m_down, m_evt_vld, m_pend_vld;
    logic [1:0]    m_evt_code [NB];
    logic [1:0]    m_pend_code [NB];
    int            m_tp [NB];
    int            m_cyc, m_cnt;
    logic          m_ovf;
    logic [NB-1:0] m_hist [$];
    logic [4:0]    exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ncmp++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_ds = '0; m_down = '0;
        m_evt_vld = '0; m_pend_vld = '0; m_ovf = 1'b0;
        m_cyc = 0; m_cnt = 0;
        for (int i = 0; i < NB; i++) begin
            m_evt_code[i] = EVT_PRESS; m_pend_code[i] = EVT_PRESS; m_tp[i] = 0;
        end
        m_hist.delete();
        exp_q.delete();
    endtask

    // One clock edge of the reference behaviour, using pre-edge values.
    task automatic m_step();
        bit pop, push, drop, all_diff;
        int sel, d;
        if (!rstn) begin
            m_reset();
            return;
        end
        pop = (m_cnt > 0) && ready;
        sel = -1;
        for (int i = NB - 1; i >= 0; i--) if (m_pend_vld[i]) sel = i;
        push = (sel >= 0) && ((m_cnt < DEPTH) || pop);
        if (pop) m_cnt--;
        if (push) begin
            m_cnt++;
            exp_q.push_back({3'(sel), m_pend_code[sel]});
            m_pend_vld[sel] = 1'b0;
        end
        drop = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (m_evt_vld[i]) begin
                if (m_pend_vld[i]) drop = 1'b1;
                else begin
                    m_pend_vld[i]  = 1'b1;
                    m_pend_code[i] = m_evt_code[i];
                end
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;

        m_cyc++;
        for (int i = 0; i < NB; i++) begin
            m_evt_vld[i] = 1'b0;
            if (!m_down[i]) begin
                if (m_ds[i]) begin
                    m_down[i] = 1'b1; m_tp[i] = m_cyc;
                    m_evt_vld[i] = 1'b1; m_evt_code[i] = EVT_PRESS;
                end
            end else if (!m_ds[i]) begin
                m_down[i] = 1'b0;
                m_evt_vld[i] = 1'b1; m_evt_code[i] = EVT_RELEASE;
            end else begin
                d = m_cyc - m_tp[i];
                if (d == LONG) begin
                    m_evt_vld[i] = 1'b1; m_evt_code[i] = EVT_LONG;
                end else if (d > LONG && ((d - LONG) % REP) == 0) begin
                    m_evt_vld[i] = 1'b1; m_evt_code[i] = EVT_REPEAT;
                end
            end
        end

        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            for (int i = 0; i < NB; i++) begin
                all_diff = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][i] == m_ds[i]) all_diff = 1'b0;
                if (all_diff) m_ds[i] = ~m_ds[i];
            end
        end
        m_s2 = m_s1;
        m_s1 = pr;
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    initial forever begin
        @(negedge rstn);
        m_reset();
    end

    // Monitor: compares the DUT against the model mid-cycle and retires the
    // scoreboard head on every accepted event.
    initial forever begin
        @(negedge clk);
        chk("btn_state", 32'(btn_state), 32'(m_ds));
        chk("evt_valid", 32'(evt_valid), 32'(m_cnt > 0));
        chk("irq", 32'(irq), 32'(m_cnt > 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        if (!rstn) begin
            chk("rst_evt_btn", 32'(evt_btn), 32'd0);
            chk("rst_evt_code", 32'(evt_code), 32'd0);
        end
        if (evt_valid) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", 32'({evt_btn, evt_code}), 32'h1f);
            end else begin
                chk("head_event", 32'({evt_btn, evt_code}), 32'(exp_q[0]));
                if (ready) begin
                    void'(exp_q.pop_front());
                    n_hs++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        m_reset();
        cyc(3);
        rstn = 1'b1;
        cyc(5);

        // Bounce on btn0, then a clean hold
        for (int k = 0; k < 6; k++) begin
            pr[0] = ~pr[0];
            cyc(2);
        end
        pr[0] = 1'b1;
        cyc(5);
        chk("bounce_state_early", 32'(btn_state[0]), 32'd0);
        cyc(1);
        chk("bounce_state_on", 32'(btn_state[0]), 32'd1);
        cyc(25);
        pr[0] = 1'b0;
        cyc(15);

        // Long press with repeats on btn1
        pr[1] = 1'b1;
        cyc(2 + DEB + 45);
        pr[1] = 1'b0;
        cyc(20);

        // All buttons at once
        pr = '1;
        cyc(15);
        chk("simul_ovf", 32'(ovf), 32'd0);
        pr = '0;
        cyc(20);

        // Backpressure, overflow and full-with-pop
        ready = 1'b0;
        pr[2:0] = 3'b111;
        cyc(10);
        pr[2:0] = 3'b000;
        cyc(12);
        chk("bp_valid", 32'(evt_valid), 32'd1);
        chk("bp_ovf_quiet", 32'(ovf), 32'd0);
        pr[1] = 1'b1;
        cyc(12);
        chk("bp_ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        cyc(2);
        chk("bp_ovf_clr", 32'(ovf), 32'd0);
        ready = 1'b1;
        cyc(1);
        ready = 1'b0;
        cyc(5);
        chk("full_pop_valid", 32'(evt_valid), 32'd1);
        ready = 1'b1;
        pr = '0;
        cyc(30);

        // Reset while btn2 is in the repeat phase
        pr[2] = 1'b1;
        cyc(2 + DEB + 1 + LONG + 5);
        rstn = 1'b0;
        cyc(3);
        rstn = 1'b1;
        cyc(15);
        pr[2] = 1'b0;
        cyc(20);

        // Random chatter, fast then slow
        for (int n = 0; n < 700; n++) begin
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 9) == 0) pr[i] = ~pr[i];
            ready   = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 29) == 0);
            cyc(1);
        end
        for (int n = 0; n < 700; n++) begin
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 39) == 0) pr[i] = ~pr[i];
            ready   = ($urandom_range(0, 4) != 0);
            ovf_clr = ($urandom_range(0, 49) == 0);
            cyc(1);
        end

        pr = '0;
        ready = 1'b1;
        ovf_clr = 1'b0;
        cyc(80);
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("events_seen", 32'(n_hs >= 30), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
